// File: rtl/telemetry_readout_tx.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_readout_tx
// Brief    : Fetches one target's X/Y/Z/Time record from the telemetry store
//            through a registered read port, then streams it as a byte-serial
//            valid/ready frame: header {HDR_NIBBLE, target}, X, Y, Z, T and an
//            optional XOR checksum byte.
//            Optional feature macro: TELEM_TX_CHKSUM_EN (adds checksum byte 5).
// Revision : 1.0 - initial release
// ============================================================================
module telemetry_readout_tx #(
  parameter logic [3:0] HDR_NIBBLE = 4'hA,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             req_valid,
  input  logic [3:0]       req_target,
  output logic             req_ready,
  output logic             rd_en,
  output logic [3:0]       rd_target,
  input  logic [7:0]       rd_x,
  input  logic [7:0]       rd_y,
  input  logic [7:0]       rd_z,
  input  logic [7:0]       rd_t,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

`ifdef TELEM_TX_CHKSUM_EN
  localparam logic [2:0] c_LAST_IDX = 3'd5;
`else
  localparam logic [2:0] c_LAST_IDX = 3'd4;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_rd_target;
  logic [7:0]       r_x, r_y, r_z, r_t;   // shadow copy isolates the frame from store updates
  logic [2:0]       r_idx;                // index of the byte currently on tx_data
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic             r_tx_last;
  logic [CNT_W-1:0] r_frame_count;

  logic [7:0]       w_hdr;
  logic [2:0]       w_next_idx;
  logic [7:0]       w_next_byte;
  logic             w_xfer;

  assign w_hdr  = {HDR_NIBBLE, r_rd_target};
  assign w_xfer = r_tx_valid && tx_ready;

`ifdef TELEM_TX_CHKSUM_EN
  logic [7:0] w_chk;
  assign w_chk = w_hdr ^ r_x ^ r_y ^ r_z ^ r_t;
`endif

  // Select the byte that follows the one currently presented
  always_comb begin
    w_next_idx  = r_idx + 3'd1;
    w_next_byte = 8'h00;
    case (w_next_idx)
      3'd1:    w_next_byte = r_x;
      3'd2:    w_next_byte = r_y;
      3'd3:    w_next_byte = r_z;
      3'd4:    w_next_byte = r_t;
`ifdef TELEM_TX_CHKSUM_EN
      3'd5:    w_next_byte = w_chk;
`endif
      default: w_next_byte = 8'h00;
    endcase
  end

  // Request / fetch / load / send sequencer with registered stream outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_rd_target   <= 4'd0;
      r_x           <= 8'h00;
      r_y           <= 8'h00;
      r_z           <= 8'h00;
      r_t           <= 8'h00;
      r_idx         <= 3'd0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_last     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_rd_target <= req_target;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          r_state <= LOAD;
        end
        LOAD: begin
          // Store data is valid this cycle, one cycle after the read strobe
          r_x        <= rd_x;
          r_y        <= rd_y;
          r_z        <= rd_z;
          r_t        <= rd_t;
          r_idx      <= 3'd0;
          r_tx_valid <= 1'b1;
          r_tx_data  <= w_hdr;
          r_tx_last  <= 1'b0;
          r_state    <= SEND;
        end
        SEND: begin
          if (w_xfer) begin
            if (r_idx == c_LAST_IDX) begin
              r_tx_valid    <= 1'b0;
              r_tx_data     <= 8'h00;
              r_tx_last     <= 1'b0;
              r_frame_count <= r_frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
              r_state       <= IDLE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
              r_tx_last <= (w_next_idx == c_LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign rd_en       = (r_state == FETCH);
  assign rd_target   = r_rd_target;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign tx_last     = r_tx_last;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_readout_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_telemetry_readout_tx
// Brief    : Directed self-checking bench for telemetry_readout_tx with a
//            behavioural target store. Frame length follows
//            TELEM_TX_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_telemetry_readout_tx;

`ifdef TELEM_TX_CHKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  typedef logic [7:0] frame_t [6];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_target = 4'd0;
  logic       req_ready;
  logic       rd_en;
  logic [3:0] rd_target;
  logic [7:0] rd_x, rd_y, rd_z, rd_t;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       busy;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [16][4];
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  telemetry_readout_tx #(.HDR_NIBBLE(4'hA), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_target(req_target), .req_ready(req_ready),
    .rd_en(rd_en), .rd_target(rd_target),
    .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .rd_t(rd_t),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .busy(busy), .frame_count(frame_count)
  );

  // Registered-read store; outputs junk when not strobed so stale reads show up
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x <= mem[rd_target][0];
      rd_y <= mem[rd_target][1];
      rd_z <= mem[rd_target][2];
      rd_t <= mem[rd_target][3];
    end else begin
      rd_x <= 8'($urandom);
      rd_y <= 8'($urandom);
      rd_z <= 8'($urandom);
      rd_t <= 8'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input logic [3:0] tgt);
    frame_t f;
    f[0] = {4'hA, tgt};
    for (int k = 0; k < 4; k++) f[k+1] = mem[tgt][k];
    f[5] = f[0] ^ f[1] ^ f[2] ^ f[3] ^ f[4];
    return f;
  endfunction

  // Called at the negedge of the FETCH cycle; returns at the first SEND negedge
  task automatic fetch_checks(input logic [3:0] tgt);
    check_eq("fetch_rd_en", rd_en, 1'b1);
    check_eq("fetch_rd_target", rd_target, tgt);
    check_eq("fetch_busy", busy, 1'b1);
    check_eq("fetch_req_ready", req_ready, 1'b0);
    check_eq("fetch_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    check_eq("load_rd_en", rd_en, 1'b0);
    check_eq("load_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    check_eq("send_tx_valid", tx_valid, 1'b1);
  endtask

  task automatic issue_req(input logic [3:0] tgt);
    check_eq("idle_req_ready", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_target = tgt;
    @(negedge clk);
    req_valid  = 1'b0;
    req_target = 4'd0;
    fetch_checks(tgt);
  endtask

  // Consume bytes up to stop_at; optional back-pressure and pending request
  task automatic recv(input frame_t e, input bit bp, input bit hold9, input int stop_at);
    int         idx = 0;
    int         guard = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    if (bp) tx_ready = 1'b1;
    while (idx < stop_at && guard < 100) begin
      guard++;
      tx_ready = bp ? ~tx_ready : 1'b1;
      if (hold9) begin
        req_valid  = 1'b1;
        req_target = 4'd9;
        check_eq("busy_req_ready", req_ready, 1'b0);
      end
      check_eq("tx_valid_mid", tx_valid, 1'b1);
      if (stalled) check_eq("stall_hold", tx_data, held);
      if (tx_ready) begin
        check_eq($sformatf("byte%0d", idx), tx_data, e[idx]);
        check_eq($sformatf("last%0d", idx), tx_last, (idx == NB-1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = tx_data;
      end
      @(negedge clk);
    end
    if (idx < stop_at) check_eq("recv_timeout", idx, stop_at);
  endtask

  task automatic frame_done(input logic [7:0] cnt);
    check_eq("end_tx_valid", tx_valid, 1'b0);
    check_eq("end_tx_last", tx_last, 1'b0);
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_frame_count", frame_count, cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_t golden;
    golden = '{8'hAB, 8'h55, 8'hF0, 8'hAA, 8'hCC, 8'h68};
    for (int t = 0; t < 16; t++)
      for (int k = 0; k < 4; k++)
        mem[t][k] = 8'(t * 37 + k * 91 + 3);
    mem[11][0] = 8'h55; mem[11][1] = 8'hF0; mem[11][2] = 8'hAA; mem[11][3] = 8'hCC;
    mem[9][0]  = 8'h12; mem[9][1]  = 8'h34; mem[9][2]  = 8'h56; mem[9][3]  = 8'h78;

    // 1: reset then idle
    repeat (3) @(negedge clk);
    check_eq("rst_tx_valid", tx_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_req_ready0", req_ready, 1'b1);
    check_eq("idle_tx_valid", tx_valid, 1'b0);
    check_eq("idle_frame_count", frame_count, 8'h00);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_rd_en", rd_en, 1'b0);
    check_eq("idle_tx_data", tx_data, 8'h00);

    // 2: basic frame; tx_ready held high beforehand must be ignored
    tx_ready = 1'b1;
    @(negedge clk);
    check_eq("ready_ignored", tx_valid, 1'b0);
    issue_req(4'd11);
    recv(golden, 1'b0, 1'b0, NB);
    frame_done(8'd1);

    // 3: back-pressure; store contents change after load must not matter
    issue_req(4'd11);
    mem[11][0] = 8'h00; mem[11][1] = 8'h00; mem[11][2] = 8'h00; mem[11][3] = 8'h00;
    recv(golden, 1'b1, 1'b0, NB);
    frame_done(8'd2);
    mem[11][0] = 8'h55; mem[11][1] = 8'hF0; mem[11][2] = 8'hAA; mem[11][3] = 8'hCC;

    // 4: request held while busy starts right after the frame ends
    tx_ready = 1'b1;
    issue_req(4'd11);
    recv(golden, 1'b0, 1'b1, NB);
    frame_done(8'd3);
    check_eq("pending_req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_target = 4'd0;
    fetch_checks(4'd9);
    check_eq("hdr_a9", tx_data, 8'hA9);
    recv(mk(4'd9), 1'b0, 1'b0, NB);
    frame_done(8'd4);

    // 5: reset after byte 2 transferred
    issue_req(4'd5);
    recv(mk(4'd5), 1'b0, 1'b0, 3);
    check_eq("pre_rst_tx_valid", tx_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_tx_valid", tx_valid, 1'b0);
    check_eq("mid_rst_frame_count", frame_count, 8'h00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue_req(4'd5);
    recv(mk(4'd5), 1'b0, 1'b0, NB);
    frame_done(8'd1);

    // 6: counter wrap after 256 completed frames
    exp_cnt = 8'd1;
    for (int i = 0; i < 255; i++) begin
      issue_req(4'(i));
      recv(mk(4'(i)), 1'b0, 1'b0, NB);
      exp_cnt = exp_cnt + 8'd1;
      frame_done(exp_cnt);
    end
    check_eq("wrap_zero", frame_count, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
